// File: rtl/nios_q_sig_capture.sv
// Avalon-MM capture FIFO for the q_sig result bus; samples stage one cycle before entering the FIFO.
// Read latency 1 (readdata registered, DATA read pops); full FIFO drops samples and sets sticky overflow.
module nios_q_sig_capture #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  input  logic              in_valid,
  output logic              irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_LIVE = 2'd3;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              en_q, en_d;
  logic              irq_en_q, irq_en_d;
  logic [5:0]        thr_q, thr_d;
  logic [DATA_W-1:0] live_q, live_d;
  logic              stg_vld_q, stg_vld_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              irq_q, irq_d;

  logic              rd_en, wr_en;
  logic              full, empty;
  logic              flush, pop, push_ok, ovf_set, ovf_clr;
  logic [5:0]        cnt_ext;
  logic [CNT_W-1:0]  push_inc, pop_dec;

  logic unused_wdata;
  assign unused_wdata = ^{writedata[31:14], writedata[7:3]};

  assign rd_en   = chipselect & read;
  assign wr_en   = chipselect & write;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign cnt_ext = 6'(count_q);

  // Flush outranks everything that would touch FIFO occupancy this cycle.
  assign flush   = wr_en & (address == A_CTRL) & writedata[2];
  assign pop     = rd_en & (address == A_DATA) & ~empty;
  assign push_ok = stg_vld_q & ~flush & (~full | pop);
  assign ovf_set = stg_vld_q & ~flush & full & ~pop;
  assign ovf_clr = wr_en & (address == A_STAT) & writedata[10];

  assign push_inc = {{(CNT_W-1){1'b0}}, push_ok};
  assign pop_dec  = {{(CNT_W-1){1'b0}}, pop};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + push_inc - pop_dec;
    end
  end

  always_comb begin
    ovf_d    = ovf_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    thr_d    = thr_q;
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    if (wr_en && (address == A_CTRL)) begin
      en_d     = writedata[0];
      irq_en_d = writedata[1];
      thr_d    = writedata[13:8];
    end
  end

  // A sample staged in the same cycle as a flush is discarded with it.
  always_comb begin
    live_d    = in_port;
    stg_vld_d = en_q & in_valid & ~flush;
    irq_d     = irq_en_q & (ovf_q | ((thr_q != 6'd0) & (cnt_ext >= thr_q)));
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      unique case (address)
        A_DATA: rdata_d = pop ? {1'b1, 15'b0, 16'(mem[rd_ptr_q])} : 32'd0;
        A_STAT: rdata_d = {21'b0, ovf_q, full, empty, 2'b0, cnt_ext};
        A_CTRL: rdata_d = {18'b0, thr_q, 5'b0, 1'b0, irq_en_q, en_q};
        A_LIVE: rdata_d = 32'(live_q);
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      thr_q     <= '0;
      live_q    <= '0;
      stg_vld_q <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      thr_q     <= thr_d;
      live_q    <= live_d;
      stg_vld_q <= stg_vld_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= live_q;
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios_q_sig_capture.sv
// Directed plus random bench for nios_q_sig_capture against a queue-based register/FIFO model.
module tb_nios_q_sig_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, read, write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] in_port;
  logic        in_valid;
  logic        irq;

  always #5 clk = ~clk;

  nios_q_sig_capture #(.DEPTH(8), .DATA_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .in_valid(in_valid), .irq(irq)
  );

  int checks = 0;
  int fails  = 0;

  // Model: FIFO contents, registers, the one-cycle input stage and the registered outputs.
  int          q[$];
  bit          m_ovf, m_en, m_ie, m_sv;
  int          m_thr;
  logic [15:0] m_live;
  logic [31:0] m_rd;
  logic        m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_en = 0; m_ie = 0; m_sv = 0; m_thr = 0;
    m_live = '0; m_rd = '0; m_irq = 1'b0;
  endtask

  task automatic step(input bit c, input bit r, input bit w, input logic [1:0] a,
                      input logic [31:0] wd, input logic [15:0] din, input bit iv);
    int sz;
    bit rd_e, wr_e, fl, pp, set, nsv;
    @(negedge clk);
    chipselect = c; read = r; write = w; address = a;
    writedata = wd; in_port = din; in_valid = iv;
    sz   = q.size();
    rd_e = c && r;
    wr_e = c && w;
    fl   = wr_e && (a == 2'd2) && wd[2];
    pp   = rd_e && (a == 2'd0) && (sz > 0);
    m_irq = m_ie && (m_ovf || (m_thr != 0 && sz >= m_thr));
    if (rd_e) begin
      case (a)
        2'd0: m_rd = pp ? (32'h8000_0000 | 32'(q[0])) : 32'd0;
        2'd1: begin
          m_rd = 32'(sz);
          if (sz == 0) m_rd |= 32'h100;
          if (sz == 8) m_rd |= 32'h200;
          if (m_ovf)   m_rd |= 32'h400;
        end
        2'd2: m_rd = (32'(m_thr) << 8) | (m_ie ? 32'h2 : 32'h0) | (m_en ? 32'h1 : 32'h0);
        default: m_rd = 32'(m_live);
      endcase
    end
    set = 0;
    if (fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (m_sv) begin
        if (sz == 8 && !pp) set = 1;
        else q.push_back(int'(m_live));
      end
    end
    if (set) m_ovf = 1;
    else if (wr_e && a == 2'd1 && wd[10]) m_ovf = 0;
    nsv = m_en && iv && !fl;
    if (wr_e && a == 2'd2) begin
      m_en = wd[0]; m_ie = wd[1]; m_thr = int'(wd[13:8]);
    end
    m_sv = nsv;
    m_live = din;
    @(posedge clk);
    #1;
    chk("readdata", readdata, m_rd);
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic rd(input logic [1:0] a);  step(1, 1, 0, a, 32'd0, 16'd0, 0); endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d); step(1, 0, 1, a, d, 16'd0, 0); endtask
  task automatic push(input logic [15:0] d); step(0, 0, 0, 2'd0, 32'd0, d, 1); endtask
  task automatic idle(); step(0, 0, 0, 2'd0, 32'd0, 16'd0, 0); endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    chipselect = 0; read = 0; write = 0; address = '0;
    writedata = '0; in_port = '0; in_valid = 0;
    do_reset();

    rd(2'd1); chk("status_after_reset", readdata, 32'h0000_0100);
    rd(2'd0); chk("data_empty", readdata, 32'd0);

    wr(2'd2, 32'h1);
    push(16'h1234); push(16'hBEEF); idle();
    rd(2'd1); chk("status_two", readdata, 32'h0000_0002);
    rd(2'd0); chk("data_1234", readdata, 32'h8000_1234);
    rd(2'd0); chk("data_beef", readdata, 32'h8000_BEEF);
    rd(2'd0); chk("data_drained", readdata, 32'd0);
    rd(2'd1); chk("status_empty", readdata, 32'h0000_0100);

    for (int i = 1; i <= 10; i++) push(16'(i));
    idle();
    rd(2'd1); chk("status_overflow", readdata, 32'h0000_0608);
    wr(2'd1, 32'h400);
    rd(2'd1); chk("status_ovf_clr", readdata, 32'h0000_0208);

    push(16'h00AA);
    rd(2'd0); chk("full_push_pop", readdata, 32'h8000_0001);
    rd(2'd1); chk("full_no_ovf", readdata, 32'h0000_0208);
    for (int i = 0; i < 8; i++) rd(2'd0);
    chk("last_is_aa", readdata, 32'h8000_00AA);

    wr(2'd2, 32'h0303);
    push(16'h11); push(16'h22); push(16'h33);
    idle(); chk("irq_n1", {31'b0, irq}, 32'd0);
    idle(); chk("irq_n2", {31'b0, irq}, 32'd1);
    rd(2'd0); chk("irq_pop_hold", {31'b0, irq}, 32'd1);
    idle(); chk("irq_pop_drop", {31'b0, irq}, 32'd0);
    rd(2'd0); rd(2'd0);

    wr(2'd2, 32'h1);
    for (int i = 0; i < 4; i++) push(16'(16'h40 + i));
    idle();
    rd(2'd1); chk("status_four", readdata, 32'h0000_0004);
    step(1, 0, 1, 2'd2, 32'h5, 16'h0077, 1);
    idle();
    rd(2'd1); chk("status_flushed", readdata, 32'h0000_0100);
    rd(2'd0); chk("flush_drop", readdata, 32'd0);
    rd(2'd2); chk("ctrl_flush_reads0", readdata, 32'h0000_0001);

    step(0, 0, 0, 2'd0, 32'd0, 16'h5A5A, 0);
    step(1, 1, 0, 2'd3, 32'd0, 16'h1111, 0);
    chk("live_lag", readdata, 32'h0000_5A5A);

    for (int n = 0; n < 1200; n++) begin
      logic [1:0]  a;
      logic [31:0] wd;
      a  = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (a == 2'd2)
        wd = (32'($urandom_range(0, 10)) << 8) | ($urandom_range(0, 9) == 0 ? 32'h4 : 32'h0) |
             (32'($urandom_range(0, 1)) << 1) | ($urandom_range(0, 7) != 0 ? 32'h1 : 32'h0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           a, wd, 16'($urandom), $urandom_range(0, 1) == 1);
      if (n == 600) begin
        #2;
        do_reset();
        wr(2'd2, 32'h0203);
      end
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
